// File: rtl/axis_pixel_repacker.sv
// AXI4-Stream pixel repacker: PPC_IN pixels/beat in, PPC_OUT pixels/beat out.
// SOF/EOL are regenerated from frame counters; incoming markers are only checked.
//
// state  | meaning
// SYNC   | discarding beats until one arrives with tuser=1
// ACTIVE | counting pixels of a frame; frame_done set means SOF is expected next
module axis_pixel_repacker #(
    parameter int PIXEL_WIDTH  = 24,
    parameter int PPC_IN       = 2,
    parameter int PPC_OUT      = 1,
    parameter int FRAME_WIDTH  = 64,
    parameter int FRAME_HEIGHT = 48
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [PIXEL_WIDTH*PPC_IN-1:0]  s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tuser,
    input  logic                           s_axis_tlast,
    output logic [PIXEL_WIDTH*PPC_OUT-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tuser,
    output logic                           m_axis_tlast,
    output logic [15:0]                    frame_count,
    output logic                           err_eol_early,
    output logic                           err_eol_late,
    output logic                           err_sof_early,
    output logic                           err_sof_missing
);
    localparam int          IN_W     = PIXEL_WIDTH * PPC_IN;
    localparam int          OUT_W    = PIXEL_WIDTH * PPC_OUT;
    localparam bit          GATHER   = (PPC_OUT > PPC_IN);
    localparam int          R        = GATHER ? (PPC_OUT / PPC_IN) : (PPC_IN / PPC_OUT);
    localparam logic [7:0]  R_LAST   = 8'(R - 1);
    localparam logic [15:0] COL_LAST = 16'(FRAME_WIDTH - PPC_IN);
    localparam logic [15:0] ROW_LAST = 16'(FRAME_HEIGHT - 1);
    localparam logic [15:0] COL_STEP = 16'(PPC_IN);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t      state;
    logic        frame_done;
    logic        ready_en;
    logic        dp_ready;
    logic [15:0] in_col;
    logic [15:0] in_row;
    logic [15:0] col;
    logic [15:0] row;
    logic        in_acc;
    logic        take;
    logic        restart;
    logic        sof_early;
    logic        sof_miss;
    logic        eol_early;
    logic        eol_late;
    logic        beat_sof;
    logic        beat_eol;
    logic        frame_end;

    assign s_axis_tready = ready_en && dp_ready;
    assign in_acc        = s_axis_tvalid && s_axis_tready;

    // Classify the accepted beat: take = its pixels go to the datapath.
    always_comb begin
        take      = 1'b0;
        restart   = 1'b0;
        sof_early = 1'b0;
        sof_miss  = 1'b0;
        if (in_acc) begin
            if (state == SYNC || frame_done) begin
                take     = s_axis_tuser;
                restart  = s_axis_tuser;
                sof_miss = (state == ACTIVE) && !s_axis_tuser;
            end else begin
                take      = 1'b1;
                restart   = s_axis_tuser;
                sof_early = s_axis_tuser;
            end
        end
        col       = restart ? 16'd0 : in_col;
        row       = restart ? 16'd0 : in_row;
        beat_sof  = (col == 16'd0) && (row == 16'd0);
        beat_eol  = (col == COL_LAST);
        frame_end = beat_eol && (row == ROW_LAST);
        eol_early = take && !sof_early && s_axis_tlast && !beat_eol;
        eol_late  = take && !sof_early && !s_axis_tlast && beat_eol;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= SYNC;
            frame_done      <= 1'b0;
            ready_en        <= 1'b0;
            in_col          <= '0;
            in_row          <= '0;
            frame_count     <= '0;
            err_eol_early   <= 1'b0;
            err_eol_late    <= 1'b0;
            err_sof_early   <= 1'b0;
            err_sof_missing <= 1'b0;
        end else begin
            ready_en        <= 1'b1;
            err_eol_early   <= eol_early;
            err_eol_late    <= eol_late;
            err_sof_early   <= sof_early;
            err_sof_missing <= sof_miss;
            if (sof_miss) begin
                state      <= SYNC;
                frame_done <= 1'b0;
            end else if (take) begin
                state      <= ACTIVE;
                frame_done <= frame_end;
                if (beat_eol) begin
                    in_col <= '0;
                    in_row <= frame_end ? 16'd0 : row + 16'd1;
                end else begin
                    in_col <= col + COL_STEP;
                    in_row <= row;
                end
                if (frame_end)
                    frame_count <= frame_count + 16'd1;
            end
        end
    end

    generate
        if (GATHER) begin : g_gather
            logic [OUT_W-1:0] acc;
            logic [7:0]       g_cnt;
            logic [7:0]       g_eff;
            logic             grp_sof;
            logic [OUT_W-1:0] out_data;
            logic             out_valid;
            logic             out_user;
            logic             out_last;

            // An early SOF drops whatever partial group was collected.
            assign g_eff    = restart ? 8'd0 : g_cnt;
            assign dp_ready = (g_cnt != R_LAST) || !out_valid || m_axis_tready;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    acc       <= '0;
                    g_cnt     <= '0;
                    grp_sof   <= 1'b0;
                    out_data  <= '0;
                    out_valid <= 1'b0;
                    out_user  <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    if (out_valid && m_axis_tready)
                        out_valid <= 1'b0;
                    if (take) begin
                        if (g_eff == R_LAST) begin
                            out_data  <= {s_axis_tdata, acc[OUT_W-1:IN_W]};
                            out_valid <= 1'b1;
                            out_user  <= grp_sof;
                            out_last  <= beat_eol;
                            g_cnt     <= '0;
                        end else begin
                            acc   <= {s_axis_tdata, acc[OUT_W-1:IN_W]};
                            g_cnt <= g_eff + 8'd1;
                            if (g_eff == 8'd0)
                                grp_sof <= beat_sof;
                        end
                    end
                end
            end

            assign m_axis_tdata  = out_data;
            assign m_axis_tvalid = out_valid;
            assign m_axis_tuser  = out_user;
            assign m_axis_tlast  = out_last;
        end else begin : g_split
            logic [IN_W-1:0] hold;
            logic            hold_valid;
            logic            hold_sof;
            logic            hold_eol;
            logic [7:0]      sub;

            assign dp_ready = !hold_valid || (m_axis_tready && sub == R_LAST);

            // Hold shifts down one output beat per accepted sub-beat, LSB first.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    hold       <= '0;
                    hold_valid <= 1'b0;
                    hold_sof   <= 1'b0;
                    hold_eol   <= 1'b0;
                    sub        <= '0;
                end else begin
                    if (hold_valid && m_axis_tready) begin
                        if (sub == R_LAST) begin
                            hold_valid <= 1'b0;
                        end else begin
                            hold <= hold >> OUT_W;
                            sub  <= sub + 8'd1;
                        end
                    end
                    if (take) begin
                        hold       <= s_axis_tdata;
                        hold_valid <= 1'b1;
                        hold_sof   <= beat_sof;
                        hold_eol   <= beat_eol;
                        sub        <= '0;
                    end
                end
            end

            assign m_axis_tdata  = hold[OUT_W-1:0];
            assign m_axis_tvalid = hold_valid;
            assign m_axis_tuser  = hold_valid && hold_sof && (sub == 8'd0);
            assign m_axis_tlast  = hold_valid && hold_eol && (sub == R_LAST);
        end
    endgenerate

endmodule

// File: doc/axis_pixel_repacker.md
Name: axis_pixel_repacker

Overview:
- Parametrised successor to the fixed 2-pixel/48-bit frame splicer: an AXI4-Stream video block that re-packs PPC_IN pixels per beat into PPC_OUT pixels per beat.
- Generates SOF (tuser) and EOL (tlast) from its own frame counters rather than forwarding them.
- Checks incoming tuser/tlast against FRAME_WIDTH x FRAME_HEIGHT, flags errors and resynchronises on SOF.
- Sits between the video source and the downstream pixel pipeline.

Parameters:
- PIXEL_WIDTH, 24, bits per pixel (RGB888).
- PPC_IN, 2, pixels per input beat.
- PPC_OUT, 1, pixels per output beat; max(PPC_IN,PPC_OUT) must be an integer multiple of min(PPC_IN,PPC_OUT).
- FRAME_WIDTH, 64, pixels per line; must be divisible by PPC_IN and PPC_OUT.
- FRAME_HEIGHT, 48, lines per frame.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  PIXEL_WIDTH*PPC_IN  input pixels; raster-first pixel in LSBs
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tuser  in  1  SOF, first beat of frame
- s_axis_tlast  in  1  EOL, last beat of line
- m_axis_tdata  out  PIXEL_WIDTH*PPC_OUT  output pixels; raster-first pixel in LSBs
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tuser  out  1  SOF on first output beat of frame
- m_axis_tlast  out  1  EOL on last output beat of each line
- frame_count  out  16  completed frames, wraps at 0xFFFF->0
- err_eol_early  out  1  one-cycle pulse
- err_eol_late  out  1  one-cycle pulse
- err_sof_early  out  1  one-cycle pulse
- err_sof_missing  out  1  one-cycle pulse

Behaviour:
- Clock and reset: clock aclk; reset aresetn, synchronous, active-low.
- Reset values: all outputs 0 (including s_axis_tready), state SYNC, counters cleared, pack/hold registers empty.
- Reset mid-frame drops all buffered pixels; no partial beat is emitted afterwards.
- Handshake: transfer on valid&&ready. m_axis_tvalid/tdata/tuser/tlast stay stable until accepted. m_axis_tvalid never depends combinationally on m_axis_tready.
- FSM SYNC: s_axis_tready=1. Beats with tuser=0 are discarded silently. An accepted beat with tuser=1 is processed as frame pixel 0 -> ACTIVE.
- FSM ACTIVE: counters in_col (pixels, 0..FRAME_WIDTH-1) and in_row advance per accepted input beat by PPC_IN.
- Split mode (PPC_IN>PPC_OUT, R=PPC_IN/PPC_OUT):
  - Input beat loads a hold register; R output beats are emitted LSB-first.
  - s_axis_tready=1 when hold is empty, or when the last sub-beat is being accepted that cycle.
  - Sustains 1 output beat/cycle.
- Gather mode (PPC_OUT>PPC_IN, R=PPC_OUT/PPC_IN):
  - Accumulates R input beats; the first-received beat goes in the LSBs.
  - Output is presented the cycle after the R-th beat is accepted.
  - Accepts input while accumulating, or while the output register is empty or being accepted.
- Equal mode: single register slice.
- Latency: 1 cycle from the completing input acceptance to m_axis_tvalid.
- m_axis_tuser=1 only on the output beat containing frame pixel (0,0).
- m_axis_tlast=1 on the output beat containing pixel FRAME_WIDTH-1 of each line; derived from counters, never from s_axis_tlast.
- tlast checks:
  - s_axis_tlast=1 on a beat not ending the line -> err_eol_early.
  - s_axis_tlast=0 on the beat ending the line -> err_eol_late.
  - Data passes unmodified in both cases.
- End of frame: after the last pixel of row FRAME_HEIGHT-1, frame_count increments (pulses with the last input beat); the FSM stays in ACTIVE expecting SOF.
- Next accepted beat after end of frame:
  - tuser=0 -> err_sof_missing, beat discarded, enter SYNC.
  - tuser=1 -> normal new frame.
- tuser=1 mid-frame (not pixel 0):
  - err_sof_early pulse.
  - A partial gather group is discarded; a pending output beat is still delivered.
  - Counters restart; the beat is treated as pixel (0,0).
- Simultaneous events: err_sof_early has priority and suppresses the EOL checks for that beat. At most one error pulse per cycle.

Test Plan:
- Defaults, m_axis_tready=1: 1536 input beats, pixels p0..p3071 -> 3072 output beats in order p0,p1,...; tuser only on beat 0; tlast on beats 63,127,...,3071; frame_count=1; no error pulses.
- Same frame, m_axis_tready high 1 cycle in 3, s_axis_tvalid randomly gapped -> identical output sequence, no drops or duplicates, tdata stable while stalled.
- 5 beats with tuser=0 before a valid frame -> all 5 accepted and discarded, first output is p0 with tuser=1, no error pulse.
- s_axis_tlast=1 on input beat 10 of row 0, and tlast missing on beat 31 of row 1 -> one err_eol_early, one err_eol_late; output tlast still at pixel 63 of each row.
- tuser=1 on beat 0 of row 3 -> err_sof_early; output tuser on that beat's first sub-beat; frame_count increments only after 48 further complete lines.
- PPC_IN=1, PPC_OUT=4, inputs A,B,C,D -> one output beat {D,C,B,A} (A in LSBs). Assert aresetn=0 after 2 beats of the next group -> all outputs 0, no partial beat emitted after reset release.
